// File: rtl/fsm_mestre_envase.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_mestre_envase
//  Description : Master sequencer for the bottling line. It walks the
//                conveyor through the fill, cork and exit stations, times the
//                filling valve and the corking actuator, tracks cork stock and
//                counts finished bottles (0..99).
//                Optional move watchdog: define FSM_MESTRE_WATCHDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_mestre_envase #(
  parameter int unsigned T_ENCHER    = 150_000_000,
  parameter int unsigned T_VEDAR     = 50_000_000,
  parameter int unsigned T_TIMEOUT   = 500_000_000,
  parameter int unsigned ESTOQUE_INI = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       repor_rolhas,
  input  logic       tarefa_concluida,
  output logic       cmd_mover,
  output logic [1:0] sel_destino,
  output logic       valvula_ativa,
  output logic       vedador_ativo,
  output logic       alarme_rolha,
  output logic [7:0] estoque,
  output logic [6:0] contador_garrafas,
  output logic       erro_timeout,
  output logic [3:0] estado
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_MOVE_ENCH  = 4'd1;
  localparam logic [3:0] S_ENCHENDO   = 4'd2;
  localparam logic [3:0] S_MOVE_VED   = 4'd3;
  localparam logic [3:0] S_VEDANDO    = 4'd4;
  localparam logic [3:0] S_MOVE_SAIDA = 4'd5;
  localparam logic [3:0] S_CONTA      = 4'd6;
  localparam logic [3:0] S_ALARME     = 4'd7;
  localparam logic [3:0] S_ERRO       = 4'd8;

  // Dwell counter values on the last cycle of each timed state
  localparam logic [31:0] C_ENCH_LAST    = 32'(T_ENCHER - 1);
  localparam logic [31:0] C_VED_LAST     = 32'(T_VEDAR - 1);
  localparam logic [31:0] C_TIMEOUT_LAST = 32'(T_TIMEOUT - 1);
  localparam logic [7:0]  C_STOCK_FULL   = 8'(ESTOQUE_INI);
  localparam logic [7:0]  C_STOCK_TAKEN  = 8'(ESTOQUE_INI - 1);

`ifdef FSM_MESTRE_WATCHDOG_EN
  localparam logic C_WD_EN = 1'b1;
`else
  localparam logic C_WD_EN = 1'b0;
`endif

  logic [3:0]  state_q, state_d;
  logic [31:0] dwell_q, dwell_d;
  logic [7:0]  estoque_q, estoque_d;
  logic [6:0]  contador_q, contador_d;

  logic w_wd_fire;
  logic w_stock_take;

  // Watchdog fires on the T_TIMEOUT-th consecutive MOVE cycle without arrival
  assign w_wd_fire    = C_WD_EN && !tarefa_concluida && (dwell_q == C_TIMEOUT_LAST);
  // A cork is consumed on the MOVE_VED -> VEDANDO edge
  assign w_stock_take = (state_q == S_MOVE_VED) && tarefa_concluida && (estoque_q != 8'd0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (start) state_d = S_MOVE_ENCH;
      S_MOVE_ENCH: begin
        if (tarefa_concluida) state_d = S_ENCHENDO;
        else if (w_wd_fire)   state_d = S_ERRO;
      end
      S_ENCHENDO:   if (dwell_q == C_ENCH_LAST) state_d = S_MOVE_VED;
      S_MOVE_VED: begin
        if (tarefa_concluida) state_d = (estoque_q != 8'd0) ? S_VEDANDO : S_ALARME;
        else if (w_wd_fire)   state_d = S_ERRO;
      end
      S_ALARME:     if (repor_rolhas) state_d = S_VEDANDO;
      S_VEDANDO:    if (dwell_q == C_VED_LAST) state_d = S_MOVE_SAIDA;
      S_MOVE_SAIDA: begin
        if (tarefa_concluida) state_d = S_CONTA;
        else if (w_wd_fire)   state_d = S_ERRO;
      end
      S_CONTA:      state_d = start ? S_MOVE_ENCH : S_IDLE;
      S_ERRO:       state_d = S_ERRO;
      default:      state_d = S_IDLE;
    endcase
  end

  // Datapath next values: dwell counter, cork stock, bottle counter
  always_comb begin
    if (state_d != state_q)      dwell_d = 32'd0;
    else if (dwell_q != '1)      dwell_d = dwell_q + 32'd1;
    else                         dwell_d = dwell_q;

    // A refill landing on a cork-consuming edge still loses that cork
    estoque_d = estoque_q;
    if (repor_rolhas)
      estoque_d = (w_stock_take || (state_q == S_ALARME)) ? C_STOCK_TAKEN : C_STOCK_FULL;
    else if (w_stock_take)
      estoque_d = estoque_q - 8'd1;

    contador_d = contador_q;
    if (state_q == S_CONTA)
      contador_d = (contador_q == 7'd99) ? 7'd0 : contador_q + 7'd1;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q    <= 32'd0;
      estoque_q  <= C_STOCK_FULL;
      contador_q <= 7'd0;
    end else begin
      dwell_q    <= dwell_d;
      estoque_q  <= estoque_d;
      contador_q <= contador_d;
    end
  end

  // Moore output decode from the state register
  always_comb begin
    cmd_mover     = 1'b0;
    sel_destino   = 2'd0;
    valvula_ativa = 1'b0;
    vedador_ativo = 1'b0;
    alarme_rolha  = 1'b0;
    erro_timeout  = 1'b0;
    case (state_q)
      S_MOVE_ENCH:  cmd_mover = 1'b1;
      S_ENCHENDO:   valvula_ativa = 1'b1;
      S_MOVE_VED: begin
        cmd_mover   = 1'b1;
        sel_destino = 2'd1;
      end
      S_VEDANDO: begin
        vedador_ativo = 1'b1;
        sel_destino   = 2'd1;
      end
      S_ALARME: begin
        alarme_rolha = 1'b1;
        sel_destino  = 2'd1;
      end
      S_MOVE_SAIDA: begin
        cmd_mover   = 1'b1;
        sel_destino = 2'd2;
      end
      S_CONTA:      sel_destino = 2'd2;
      S_ERRO:       erro_timeout = C_WD_EN;
      default:      cmd_mover = 1'b0;
    endcase
  end

  assign estoque           = estoque_q;
  assign contador_garrafas = contador_q;
  assign estado            = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_mestre_envase.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsm_mestre_envase
//  Description : Directed self-checking bench for fsm_mestre_envase with a
//                conveyor/sensor model that parks 5 cycles after a move starts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_mestre_envase;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       repor_rolhas = 1'b0;
  logic       tarefa_concluida = 1'b0;
  logic       cmd_mover;
  logic [1:0] sel_destino;
  logic       valvula_ativa;
  logic       vedador_ativo;
  logic       alarme_rolha;
  logic [7:0] estoque;
  logic [6:0] contador_garrafas;
  logic       erro_timeout;
  logic [3:0] estado;

  int total = 0;
  int bad   = 0;

  logic       block_cork = 1'b0;
  logic [2:0] mv_cnt = 3'd0;
  logic [1:0] park_pos = 2'd0;
  logic       cmd_prev = 1'b0;
  logic       tc_prev = 1'b0;

  always #5 clk = ~clk;

  fsm_mestre_envase #(
    .T_ENCHER(4), .T_VEDAR(3), .T_TIMEOUT(20), .ESTOQUE_INI(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .repor_rolhas(repor_rolhas),
    .tarefa_concluida(tarefa_concluida), .cmd_mover(cmd_mover),
    .sel_destino(sel_destino), .valvula_ativa(valvula_ativa),
    .vedador_ativo(vedador_ativo), .alarme_rolha(alarme_rolha),
    .estoque(estoque), .contador_garrafas(contador_garrafas),
    .erro_timeout(erro_timeout), .estado(estado)
  );

  // Conveyor model: reaches the selected station 5 cycles after the move starts,
  // stays parked (done high) until the move command drops
  always @(posedge clk) begin
    if (reset || !cmd_mover) begin
      tarefa_concluida <= 1'b0;
      mv_cnt           <= 3'd0;
    end else if (!tarefa_concluida) begin
      if (mv_cnt != 3'd4) mv_cnt <= mv_cnt + 3'd1;
      else if (!(block_cork && sel_destino == 2'd1)) begin
        tarefa_concluida <= 1'b1;
        park_pos         <= sel_destino;
      end
    end
  end

  // Handshake monitor: no move rises on a stale done; arrivals at the right station
  always @(negedge clk) begin
    logic [1:0] exp_pos;
    if (cmd_mover && !cmd_prev) begin
      total++;
      if (tarefa_concluida !== 1'b0) begin
        bad++;
        $display("FAIL handshake_stale_done: cmd_mover rose with tarefa_concluida=%b (need 0)", tarefa_concluida);
      end
    end
    if (tarefa_concluida && !tc_prev) begin
      case (estado)
        4'd1:    exp_pos = 2'd0;
        4'd3:    exp_pos = 2'd1;
        4'd5:    exp_pos = 2'd2;
        default: exp_pos = 2'd3;
      endcase
      total++;
      if (park_pos !== exp_pos) begin
        bad++;
        $display("FAIL handshake_station: parked at %0d in state %0d, need %0d", park_pos, estado, exp_pos);
      end
    end
    cmd_prev = cmd_mover;
    tc_prev  = tarefa_concluida;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repor_rolhas = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      repor_rolhas = alarme_rolha;
      if (estado == s) begin
        found = 1'b1;
        break;
      end
    end
    repor_rolhas = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (estado !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d need 0", estado); end
    total++;
    if (estoque !== 8'd2) begin bad++; $display("FAIL reset_estoque: got %0d need 2", estoque); end
    total++;
    if (contador_garrafas !== 7'd0) begin bad++; $display("FAIL reset_contador: got %0d need 0", contador_garrafas); end
    total++;
    if ({cmd_mover, sel_destino, valvula_ativa, vedador_ativo, alarme_rolha, erro_timeout} !== 7'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b need 0000000",
               {cmd_mover, sel_destino, valvula_ativa, vedador_ativo, alarme_rolha, erro_timeout});
    end
    reset = 1'b0;
  endtask

  task automatic test_single_bottle();
    int  nv = 0, nd = 0;
    bit  seen_conta = 1'b0, done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (cmd_mover !== 1'b1 || estado !== 4'd1) begin
      bad++;
      $display("FAIL start_latency: cmd=%b state=%0d need cmd=1 state=1", cmd_mover, estado);
    end
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valvula_ativa) nv++;
      if (vedador_ativo) nd++;
      if (estado == 4'd6) seen_conta = 1'b1;
      if (seen_conta && estado == 4'd0) begin done = 1'b1; break; end
    end
    total++;
    if (!done) begin bad++; $display("FAIL single_timeout: state=%0d need 0", estado); end
    total++;
    if (nv != 4) begin bad++; $display("FAIL single_valve_cycles: got %0d need 4", nv); end
    total++;
    if (nd != 3) begin bad++; $display("FAIL single_cork_cycles: got %0d need 3", nd); end
    total++;
    if (contador_garrafas !== 7'd1) begin bad++; $display("FAIL single_count: got %0d need 1", contador_garrafas); end
    total++;
    if (estoque !== 8'd1) begin bad++; $display("FAIL single_stock: got %0d need 1", estoque); end
  endtask

  task automatic test_cork_exhaustion();
    int  cyc = 0, c1 = -1, c2 = -1;
    bit  found = 1'b0;
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cyc++;
      if (estado == 4'd6) begin
        if (c1 < 0) c1 = cyc;
        else if (c2 < 0) c2 = cyc;
      end
      if (alarme_rolha) begin found = 1'b1; break; end
    end
    total++;
    if (!found) begin bad++; $display("FAIL alarm_timeout: no ALARME, state=%0d", estado); end
    total++;
    if (c2 - c1 != 26) begin bad++; $display("FAIL bottle_period: got %0d cycles need 26", c2 - c1); end
    total++;
    if (estado !== 4'd7 || sel_destino !== 2'd1 || cmd_mover !== 1'b0) begin
      bad++;
      $display("FAIL alarm_outputs: state=%0d sel=%0d cmd=%b need 7/1/0", estado, sel_destino, cmd_mover);
    end
    total++;
    if (estoque !== 8'd0 || contador_garrafas !== 7'd2) begin
      bad++;
      $display("FAIL alarm_counts: stock=%0d count=%0d need 0/2", estoque, contador_garrafas);
    end
    repeat (3) @(negedge clk);
    total++;
    if (estado !== 4'd7) begin bad++; $display("FAIL alarm_hold: got %0d need 7", estado); end
    repor_rolhas = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (estado !== 4'd4 || estoque !== 8'd1 || vedador_ativo !== 1'b1) begin
      bad++;
      $display("FAIL alarm_refill: state=%0d stock=%0d ved=%b need 4/1/1", estado, estoque, vedador_ativo);
    end
    @(negedge clk);
    repor_rolhas = 1'b0;
    start = 1'b0;
    wait_state(4'd0, 200, found);
    total++;
    if (!found || contador_garrafas !== 7'd3 || estoque !== 8'd1) begin
      bad++;
      $display("FAIL alarm_finish: state=%0d count=%0d stock=%0d need 0/3/1", estado, contador_garrafas, estoque);
    end
  endtask

  task automatic test_refill_coincide();
    bit found = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (estado == 4'd3 && tarefa_concluida) begin found = 1'b1; break; end
    end
    repor_rolhas = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (!found || estado !== 4'd4 || estoque !== 8'd1) begin
      bad++;
      $display("FAIL refill_coincide: state=%0d stock=%0d need 4/1", estado, estoque);
    end
    @(negedge clk);
    repor_rolhas = 1'b0;
    wait_state(4'd0, 200, found);
    total++;
    if (!found || contador_garrafas !== 7'd4) begin
      bad++;
      $display("FAIL refill_coincide_finish: state=%0d count=%0d need 0/4", estado, contador_garrafas);
    end
  endtask

  task automatic test_refill_idle();
    @(negedge clk);
    repor_rolhas = 1'b1;
    @(negedge clk);
    repor_rolhas = 1'b0;
    total++;
    if (estoque !== 8'd2 || estado !== 4'd0) begin
      bad++;
      $display("FAIL refill_idle: stock=%0d state=%0d need 2/0", estoque, estado);
    end
  endtask

  task automatic test_counter_wrap();
    bit found = 1'b0;
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      repor_rolhas = alarme_rolha;
      if (contador_garrafas == 7'd99) begin found = 1'b1; break; end
    end
    repor_rolhas = 1'b0;
    total++;
    if (!found) begin bad++; $display("FAIL wrap_preload: count=%0d need 99", contador_garrafas); end
    start = 1'b0;
    wait_state(4'd0, 200, found);
    total++;
    if (!found || contador_garrafas !== 7'd0) begin
      bad++;
      $display("FAIL wrap_count: state=%0d count=%0d need 0/0", estado, contador_garrafas);
    end
  endtask

  task automatic test_watchdog();
    bit found = 1'b0;
    int k = 0;
    do_reset();
    block_cork = 1'b1;
    start = 1'b1;
    wait_state(4'd3, 200, found);
    start = 1'b0;
    total++;
    if (!found) begin bad++; $display("FAIL wd_reach_move_ved: state=%0d need 3", estado); end
`ifdef FSM_MESTRE_WATCHDOG_EN
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      k++;
      if (estado == 4'd8) begin found = 1'b1; break; end
    end
    total++;
    if (!found || k != 20) begin bad++; $display("FAIL wd_latency: got %0d cycles need 20", k); end
    repeat (5) @(negedge clk);
    total++;
    if (estado !== 4'd8 || erro_timeout !== 1'b1 || cmd_mover !== 1'b0) begin
      bad++;
      $display("FAIL wd_sticky: state=%0d err=%b cmd=%b need 8/1/0", estado, erro_timeout, cmd_mover);
    end
    do_reset();
    total++;
    if (estado !== 4'd0 || erro_timeout !== 1'b0) begin
      bad++;
      $display("FAIL wd_reset_exit: state=%0d err=%b need 0/0", estado, erro_timeout);
    end
`else
    repeat (60) @(negedge clk);
    total++;
    if (estado !== 4'd3 || cmd_mover !== 1'b1 || erro_timeout !== 1'b0) begin
      bad++;
      $display("FAIL wd_disabled_wait: state=%0d cmd=%b err=%b need 3/1/0", estado, cmd_mover, erro_timeout);
    end
`endif
    block_cork = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid_fill();
    bit found = 1'b0;
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (contador_garrafas == 7'd1 && estado == 4'd2) begin found = 1'b1; break; end
    end
    total++;
    if (!found || estoque !== 8'd1) begin
      bad++;
      $display("FAIL midfill_setup: state=%0d stock=%0d need 2/1", estado, estoque);
    end
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (estado !== 4'd0 || valvula_ativa !== 1'b0 || estoque !== 8'd2 || contador_garrafas !== 7'd0) begin
      bad++;
      $display("FAIL midfill_reset: state=%0d valve=%b stock=%0d count=%0d need 0/0/2/0",
               estado, valvula_ativa, estoque, contador_garrafas);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_bottle();
    test_cork_exhaustion();
    test_refill_coincide();
    test_refill_idle();
    test_counter_wrap();
    test_watchdog();
    test_reset_mid_fill();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fsm_mestre_envase.md
# fsm_mestre_envase

Master sequencer for the bottling line. It drives the conveyor FSM through three stations: fill position, cork position and exit. At each station it selects which destination sensor the conveyor watches and issues the move command. It times the filling valve and corking actuator, tracks cork stock, and counts finished bottles.

## Interface
Parameters:
- `T_ENCHER`, default 150_000_000: fill duration in clk cycles; minimum 2.
- `T_VEDAR`, default 50_000_000: corking duration in clk cycles; minimum 2.
- `T_TIMEOUT`, default 500_000_000: watchdog limit per move, in cycles.
- `ESTOQUE_INI`, default 20: cork stock loaded at reset and on refill; range 1..255.

Ports:
- `clk` in 1: 50 MHz clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level; 1 means run the line continuously.
- `repor_rolhas` in 1: one-cycle pulse; refills cork stock.
- `tarefa_concluida` in 1: from the conveyor FSM; high while the conveyor is parked at its destination.
- `cmd_mover` out 1: move command to the conveyor FSM.
- `sel_destino` out 2: selects the conveyor destination sensor; 0 = fill, 1 = cork, 2 = exit.
- `valvula_ativa` out 1: filling valve.
- `vedador_ativo` out 1: corking actuator.
- `alarme_rolha` out 1: out-of-corks alarm; also drives the conveyor's alarm input.
- `estoque` out 8: current cork stock.
- `contador_garrafas` out 7: finished bottles, 0..99.
- `erro_timeout` out 1: sticky watchdog error.
- `estado` out 4: state code, for debug and HEX display.

## Operation
- States and codes: IDLE=0, MOVE_ENCH=1, ENCHENDO=2, MOVE_VED=3, VEDANDO=4, MOVE_SAIDA=5, CONTA=6, ALARME=7, ERRO=8.
- Outputs are Moore outputs, decoded only from the state register.
- `cmd_mover` is 1 only in the MOVE_* states.
- `sel_destino` follows the current or most recent MOVE state: 0 in IDLE, MOVE_ENCH and ENCHENDO; 1 in MOVE_VED, VEDANDO and ALARME; 2 in MOVE_SAIDA and CONTA.
- `valvula_ativa` is 1 only in ENCHENDO. `vedador_ativo` is 1 only in VEDANDO. `alarme_rolha` is 1 only in ALARME. `erro_timeout` is 1 only in ERRO.

Transitions:
- IDLE → MOVE_ENCH when `start`=1.
- MOVE_x → next work state when `tarefa_concluida`=1. MOVE_ENCH goes to ENCHENDO, MOVE_VED goes to the cork check, MOVE_SAIDA goes to CONTA.
- ENCHENDO → MOVE_VED after T_ENCHER cycles in ENCHENDO.
- Cork check on leaving MOVE_VED: if `estoque`>0, go to VEDANDO and decrement `estoque` on that transition edge. If `estoque`=0, go to ALARME.
- ALARME → VEDANDO on the `repor_rolhas` pulse. `estoque` becomes ESTOQUE_INI-1 on that same edge.
- VEDANDO → MOVE_SAIDA after T_VEDAR cycles in VEDANDO.
- CONTA lasts exactly 1 cycle. It increments `contador_garrafas` modulo 100 (99→0). It then goes to MOVE_ENCH if `start`=1, otherwise to IDLE.
- `start` falling mid-bottle has no effect until CONTA; the current bottle always completes.

Conveyor handshake:
- `cmd_mover` drops in the cycle after `tarefa_concluida` is seen.
- Every work state lasts at least 1 cycle with `cmd_mover`=0. This lets the conveyor return to its idle state before the next MOVE, so a stale `tarefa_concluida` is never seen.

Cork stock:
- `repor_rolhas` outside ALARME reloads `estoque` to ESTOQUE_INI.
- If `repor_rolhas` coincides with the VEDANDO-entry decrement, the result is ESTOQUE_INI-1.

## Timing
- Reset, evaluated at the clk edge: state IDLE, `estoque`=ESTOQUE_INI, `contador_garrafas`=0, all other outputs 0, `sel_destino`=0.
- Reset mid-operation aborts immediately; no bottle is counted.
- Latency:
  - `start` high → `cmd_mover` high after 1 edge.
  - `tarefa_concluida` high → next state after 1 edge.
- A single dwell counter serves the work states and the watchdog. It clears on every state change.
- Full cycle per bottle with no alarm: 3 conveyor moves + T_ENCHER + T_VEDAR + 1 (CONTA) cycles, plus 1 cycle of handshake per move.

## Configuration
- Macro: `FSM_MESTRE_WATCHDOG_EN`.
- Defined:
  - In each MOVE state, if `tarefa_concluida` stays 0 for T_TIMEOUT consecutive cycles, the FSM goes to ERRO.
  - ERRO: `cmd_mover`=0 and `erro_timeout`=1. Only `reset` exits ERRO.
- Undefined:
  - MOVE states wait indefinitely.
  - ERRO is unreachable and `erro_timeout` is constant 0.

## Test plan
Parameters for all scenarios: T_ENCHER=4, T_VEDAR=3, T_TIMEOUT=20, ESTOQUE_INI=2. The bench uses the conveyor FSM plus a sensor model that responds 5 cycles after a move starts.
- Single bottle: `start` high, then low after 2 cycles → `valvula_ativa` high for exactly 4 cycles. `vedador_ativo` high for exactly 3 cycles. Then `contador_garrafas`=1, `estoque`=1, final state IDLE.
- Cork exhaustion: `start` held for 3 bottles → third arrival at the cork station enters ALARME, with `alarme_rolha`=1, `sel_destino`=1 and `cmd_mover`=0. A `repor_rolhas` pulse then gives VEDANDO and `estoque`=1.
- Counter wrap: preload 99 bottles by running the line, then finish one more → `contador_garrafas`=0.
- Handshake: check that `cmd_mover` never rises while `tarefa_concluida`=1, and that each move stops at the sensor selected by `sel_destino`.
- Watchdog, with the macro defined: the sensor never fires in MOVE_VED → ERRO entered 20 cycles after MOVE_VED entry, with `erro_timeout`=1 and `cmd_mover`=0 until `reset`. With the macro undefined, the FSM stays in MOVE_VED.
- Reset mid-ENCHENDO: assert `reset` for 1 cycle → next cycle state IDLE, `valvula_ativa`=0, `estoque`=2, `contador_garrafas`=0.
